// File: rtl/demux_dispatch_ctrl_if.sv
// Beat stream into the dispatch controller and the per-channel demux handshakes out of it.
// slave = the controller, master = the upstream producer plus downstream channel sinks.
interface demux_dispatch_ctrl_if #(
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [SEL_W-1:0]  in_dest;
  logic [N_OUT-1:0]  out_valid;
  logic [N_OUT-1:0]  out_ready;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  sel;

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, out_valid, out_data, sel
  );

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, out_valid, out_data, sel
  );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Dispatch controller for a 1xN demux: holds one beat and steers it to a single channel,
// chosen round-robin over enabled channels or by the beat's destination field.
module demux_dispatch_ctrl #(
  parameter int N_OUT  = 8,
  parameter int SEL_W  = 3,
  parameter int DATA_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [N_OUT-1:0]     en_mask,
  demux_dispatch_ctrl_if.slave bus,
  output logic                 drop_err,
  output logic [15:0]          beat_cnt,
  output logic                 fsm_state
);

  // Handshakes: a beat moves on any edge where valid and ready are both high;
  // valid never waits on ready, and a presented beat stays unchanged until taken.
  typedef enum logic { IDLE = 1'b0, BUSY = 1'b1 } state_t;

  state_t            state_q, state_n;
  logic [SEL_W-1:0]  sel_q, sel_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [SEL_W-1:0]  ptr_q, ptr_n;
  logic              drop_q, drop_n;
  logic [15:0]       cnt_q, cnt_n;

  logic              drain, eligible, accept, load, drop;
  logic              rr_found;
  logic [SEL_W-1:0]  rr_idx, idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      data_q  <= '0;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      sel_q   <= sel_n;
      data_q  <= data_n;
      ptr_q   <= ptr_n;
      drop_q  <= drop_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    sel_n    = sel_q;
    data_n   = data_q;
    ptr_n    = ptr_q;
    drop_n   = 1'b0;
    cnt_n    = cnt_q;
    rr_found = 1'b0;
    rr_idx   = ptr_q;
    idx      = '0;

    // Circular search for the first enabled channel starting at ptr.
    for (int k = 0; k < N_OUT; k++) begin
      idx = ptr_q + SEL_W'(k);
      if (!rr_found && en_mask[idx]) begin
        rr_found = 1'b1;
        rr_idx   = idx;
      end
    end

    drain    = (state_q == BUSY) && bus.out_ready[sel_q];
    eligible = mode ? 1'b1 : (en_mask != '0);
    bus.in_ready = ((state_q == IDLE) || drain) && eligible;
    accept   = bus.in_valid && bus.in_ready;
    load     = accept && (mode ? en_mask[bus.in_dest] : 1'b1);
    drop     = accept && mode && !en_mask[bus.in_dest];

    if (drain) begin
      state_n = IDLE;
      cnt_n   = cnt_q + 16'd1;
    end
    if (accept && !mode) ptr_n = rr_idx + SEL_W'(1);
    if (load) begin
      state_n = BUSY;
      sel_n   = mode ? bus.in_dest : rr_idx;
      data_n  = bus.in_data;
    end
    drop_n = drop;

    bus.out_valid = (state_q == BUSY) ? (N_OUT'(1) << sel_q) : '0;
    bus.out_data  = data_q;
    bus.sel       = sel_q;
    drop_err      = drop_q;
    beat_cnt      = cnt_q;
    fsm_state     = state_q;
  end

endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Directed-vector bench for demux_dispatch_ctrl with a queue-based scoreboard of delivered beats.
module tb_demux_dispatch_ctrl;
  localparam int N_OUT  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 8;
  localparam int W      = SEL_W + DATA_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              mode;
  logic [N_OUT-1:0]  en_mask;
  logic              drop_err;
  logic [15:0]       beat_cnt;
  logic              fsm_state;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];

  demux_dispatch_ctrl_if #(.N_OUT(N_OUT), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  demux_dispatch_ctrl #(.N_OUT(N_OUT), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .mode(mode), .en_mask(en_mask), .bus(bus),
    .drop_err(drop_err), .beat_cnt(beat_cnt), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offers one beat, holding it until accepted; queues the expected delivery if one is due.
  task automatic send(input logic [DATA_W-1:0] data, input logic [SEL_W-1:0] dest,
                      input bit deliver, input logic [SEL_W-1:0] exp_ch, output int stalls);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_dest  = dest;
    stalls = 0;
    @(negedge clk);
    while (!bus.in_ready && stalls < 100) begin
      @(negedge clk);
      stalls++;
    end
    if (stalls >= 100) chk("accept_timeout", 32'(stalls), 32'd0);
    if (deliver) exp_q.push_back({exp_ch, data});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: checks one-hot against sel and scores every delivered beat.
  always @(negedge clk) begin
    if (!rst && (bus.out_valid != '0)) begin
      chk("onehot_vs_sel", 32'(bus.out_valid), 32'(N_OUT'(1) << bus.sel));
      if (bus.out_ready[bus.sel]) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'({bus.sel, bus.out_data}), 32'hFFFF_FFFF);
        end else begin
          chk("delivered_beat", 32'({bus.sel, bus.out_data}), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    int st;
    int tot;
    rst = 1'b1; mode = 1'b0; en_mask = 8'hFF;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_dest = '0; bus.out_ready = 8'hFF;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_sel", 32'(bus.sel), 32'h0);
    chk("rst_out_data", 32'(bus.out_data), 32'h0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_drop_err", 32'(drop_err), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    // Round-robin over all channels, back to back.
    tot = 0;
    for (int i = 0; i < 10; i++) begin
      send(8'(8'h10 + i), 3'd0, 1'b1, 3'(i % 8), st);
      tot += st;
    end
    chk("rr_full_stalls", 32'(tot), 32'd0);
    repeat (2) @(negedge clk);
    chk("rr_full_cnt", 32'(beat_cnt), 32'd10);

    // Sparse mask: ptr is 2, so channels 2,5,7 then wrap to 2.
    @(posedge clk); #1;
    en_mask = 8'b1010_0100;
    send(8'h20, 3'd0, 1'b1, 3'd2, st);
    send(8'h21, 3'd0, 1'b1, 3'd5, st);
    send(8'h22, 3'd0, 1'b1, 3'd7, st);
    send(8'h23, 3'd0, 1'b1, 3'd2, st);
    repeat (2) @(negedge clk);
    chk("rr_sparse_cnt", 32'(beat_cnt), 32'd14);

    // Directed beat stalled on channel 3 while other channels are ready.
    @(posedge clk); #1;
    mode = 1'b1; en_mask = 8'hFF; bus.out_ready = 8'hF7;
    send(8'hA5, 3'd3, 1'b1, 3'd3, st);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_out_valid", 32'(bus.out_valid), 32'h08);
      chk("stall_out_data", 32'(bus.out_data), 32'hA5);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    bus.out_ready = 8'hFF;
    @(negedge clk);
    chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    chk("stall_cnt", 32'(beat_cnt), 32'd15);
    chk("stall_idle", 32'(fsm_state), 32'd0);

    // Directed beat to a disabled channel is dropped.
    @(posedge clk); #1;
    en_mask = 8'hBF;
    send(8'h66, 3'd6, 1'b0, 3'd0, st);
    @(negedge clk);
    chk("drop_pulse", 32'(drop_err), 32'd1);
    chk("drop_out_valid", 32'(bus.out_valid), 32'h0);
    @(negedge clk);
    chk("drop_pulse_end", 32'(drop_err), 32'd0);
    chk("drop_cnt", 32'(beat_cnt), 32'd15);

    // Empty mask in round-robin blocks input; enabling channel 4 lets it through.
    @(posedge clk); #1;
    mode = 1'b0; en_mask = 8'h00; bus.in_valid = 1'b1; bus.in_data = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("empty_mask_in_ready", 32'(bus.in_ready), 32'd0);
    end
    @(posedge clk); #1;
    en_mask = 8'h10;
    send(8'h55, 3'd0, 1'b1, 3'd4, st);
    repeat (2) @(negedge clk);
    chk("mask10_cnt", 32'(beat_cnt), 32'd16);

    // Reset while holding a beat on channel 1 discards it.
    @(posedge clk); #1;
    en_mask = 8'h02; bus.out_ready = 8'h00;
    send(8'h77, 3'd0, 1'b0, 3'd0, st);
    @(negedge clk);
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'h02);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("post_rst_sel", 32'(bus.sel), 32'h0);
    chk("post_rst_cnt", 32'(beat_cnt), 32'd0);
    chk("post_rst_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
    en_mask = 8'hFF; bus.out_ready = 8'hFF;
    send(8'h88, 3'd0, 1'b1, 3'd0, st);
    repeat (3) @(negedge clk);
    chk("post_rst_beat_cnt", 32'(beat_cnt), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
